// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter_if
// Description : Fetch, debug and instruction-memory signal bundle.
// Revision    : 1.0
// ============================================================================
interface imem_port_arbiter_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        fetch_err;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_halt;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_err;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        input  mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        output mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter
// Description : Shares a single-ported sync-read instruction memory between
//               fetch and debug, routing the 1-cycle read response back.
//               Optional address bounds check: IMEM_ARB_BOUNDS_CHECK_EN.
// Revision    : 1.0
// ============================================================================
module imem_port_arbiter #(
    parameter int SIZE      = 256,
    parameter int DBG_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_port_arbiter_if.slave  arb_if
);

    localparam int                  c_CNT_W = $clog2(DBG_BURST) + 1;
    localparam logic [c_CNT_W-1:0]  c_BURST = c_CNT_W'(DBG_BURST);
    localparam logic [31:0]         c_NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        RSP_NONE   = 2'd0,
        RSP_FETCH  = 2'd1,
        RSP_DBG_RD = 2'd2,
        RSP_DBG_WR = 2'd3
    } rsp_state_e;

    rsp_state_e          rsp_state_q, rsp_state_d;
    logic [c_CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic        w_fetch_gnt;
    logic        w_dbg_gnt;
    logic        w_any_gnt;
    logic [31:0] w_gnt_addr;
    logic        w_addr_err;
    logic        w_rsp_err;

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        w_fetch_gnt = rst_n && arb_if.fetch_req && !arb_if.dbg_halt &&
                      (!arb_if.dbg_req || (starve_cnt_q == c_BURST));
        w_dbg_gnt   = rst_n && arb_if.dbg_req && !w_fetch_gnt;
        w_any_gnt   = w_fetch_gnt || w_dbg_gnt;
        w_gnt_addr  = w_fetch_gnt ? arb_if.fetch_addr : arb_if.dbg_addr;
    end

    assign arb_if.fetch_gnt = w_fetch_gnt;
    assign arb_if.dbg_gnt   = w_dbg_gnt;

`ifdef IMEM_ARB_BOUNDS_CHECK_EN
    logic err_q;

    assign w_addr_err = (w_gnt_addr[1:0] != 2'b00) ||
                        (w_gnt_addr[31:2] >= 30'(SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= w_any_gnt && w_addr_err;
        end
    end

    assign w_rsp_err = err_q;
`else
    assign w_addr_err = 1'b0;
    assign w_rsp_err  = 1'b0;
`endif

    always_comb begin
        arb_if.mem_en    = 1'b0;
        arb_if.mem_we    = 1'b0;
        arb_if.mem_addr  = 32'h0;
        arb_if.mem_wdata = 32'h0;
        if (w_any_gnt) begin
            arb_if.mem_en    = !w_addr_err;
            arb_if.mem_we    = w_dbg_gnt && arb_if.dbg_we && !w_addr_err;
            arb_if.mem_addr  = w_gnt_addr;
            arb_if.mem_wdata = arb_if.dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_state_q  <= RSP_NONE;
            starve_cnt_q <= '0;
        end else begin
            rsp_state_q  <= rsp_state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Counter only tracks debug wins against a live, unhalted fetch.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!arb_if.fetch_req || arb_if.dbg_halt || w_fetch_gnt) begin
            starve_cnt_d = '0;
        end else if (w_dbg_gnt) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rsp_state_d = RSP_NONE;
        if (w_fetch_gnt) begin
            rsp_state_d = RSP_FETCH;
        end else if (w_dbg_gnt) begin
            rsp_state_d = arb_if.dbg_we ? RSP_DBG_WR : RSP_DBG_RD;
        end
    end

    always_comb begin
        arb_if.fetch_rvalid = 1'b0;
        arb_if.fetch_rdata  = 32'h0;
        arb_if.fetch_err    = 1'b0;
        arb_if.dbg_rvalid   = 1'b0;
        arb_if.dbg_rdata    = 32'h0;
        arb_if.dbg_err      = 1'b0;
        case (rsp_state_q)
            RSP_FETCH: begin
                arb_if.fetch_rvalid = 1'b1;
                arb_if.fetch_rdata  = w_rsp_err ? c_NOP : arb_if.mem_rdata;
                arb_if.fetch_err    = w_rsp_err;
            end
            RSP_DBG_RD: begin
                arb_if.dbg_rvalid = 1'b1;
                arb_if.dbg_rdata  = w_rsp_err ? 32'h0 : arb_if.mem_rdata;
                arb_if.dbg_err    = w_rsp_err;
            end
            RSP_DBG_WR: begin
                arb_if.dbg_rvalid = 1'b1;
                arb_if.dbg_err    = w_rsp_err;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_port_arbiter
// Description : Directed bench for imem_port_arbiter with response scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_imem_port_arbiter;

`ifdef IMEM_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    localparam logic [31:0] EXP_OOB_F = BOUNDS ? 32'h0000_0013 : 32'hCAFE_0001;
    localparam logic [31:0] EXP_OOB_D = BOUNDS ? 32'h0000_0000 : 32'hDEAD_BEEF;

    typedef struct {
        bit          is_dbg;
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    rsp_t q[$];

    logic [31:0] mem [256];
    logic [31:0] mem_rdata_r = '0;
    bit          loaded = 1'b0;

    imem_port_arbiter_if bus ();

    imem_port_arbiter #(.SIZE(256), .DBG_BURST(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_rdata = mem_rdata_r;

    always @(posedge clk) begin
        if (!loaded) begin
            mem[0]  <= 32'hCAFE_0001;
            mem[10] <= 32'h0000_0193;
            mem[11] <= 32'h0020_0213;
            mem[12] <= 32'h0030_0393;
            loaded  <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else            mem_rdata_r <= mem[bus.mem_addr[9:2]];
        end
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Response monitor: pops the expectation due this cycle.
    always @(negedge clk) begin
        rsp_t e;
        logic ef, ed;
        ef = 1'b0;
        ed = 1'b0;
        e  = '{default: 0};
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e  = q.pop_front();
            ef = !e.is_dbg;
            ed = e.is_dbg;
        end
        if (ef || ed || bus.fetch_rvalid || bus.dbg_rvalid) begin
            chk("fetch_rvalid", 32'(bus.fetch_rvalid), 32'(ef));
            chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(ed));
            if (ef) begin
                chk("fetch_rdata", bus.fetch_rdata, e.data);
                chk("fetch_err", 32'(bus.fetch_err), 32'(e.err));
            end
            if (ed) begin
                chk("dbg_rdata", bus.dbg_rdata, e.data);
                chk("dbg_err", 32'(bus.dbg_err), 32'(e.err));
            end
        end
    end

    task automatic step(input logic fr, input logic [31:0] fa,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic h,
                        input logic efg, input logic edg,
                        input logic [31:0] erd, input logic oob);
        logic exp_men;
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.dbg_req    = dr;
        bus.dbg_we     = dw;
        bus.dbg_addr   = da;
        bus.dbg_wdata  = dwd;
        bus.dbg_halt   = h;
        @(negedge clk);
        exp_men = (efg || edg) && !(BOUNDS && oob);
        chk("fetch_gnt", 32'(bus.fetch_gnt), 32'(efg));
        chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(edg));
        chk("mem_en", 32'(bus.mem_en), 32'(exp_men));
        chk("mem_we", 32'(bus.mem_we), 32'(exp_men && edg && dw));
        if (exp_men) begin
            chk("mem_addr", bus.mem_addr, efg ? fa : da);
            if (edg && dw) chk("mem_wdata", bus.mem_wdata, dwd);
        end
        if (efg || edg) q.push_back('{edg, cyc + 1, erd, BOUNDS && oob});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Fetch of 0x2C contending with debug read of 0x28.
    task automatic contend(input logic h, input logic exp_f);
        step(1, 32'h2C, 1, 0, 32'h28, 0, h, exp_f, !exp_f,
             exp_f ? 32'h0020_0213 : 32'h0000_0193, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h28;
        bus.dbg_req    = 1'b0;
        bus.dbg_we     = 1'b0;
        bus.dbg_addr   = 32'h0;
        bus.dbg_wdata  = 32'h0;
        bus.dbg_halt   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fetch_gnt", 32'(bus.fetch_gnt), 0);
        chk("rst_dbg_gnt", 32'(bus.dbg_gnt), 0);
        chk("rst_fetch_rvalid", 32'(bus.fetch_rvalid), 0);
        chk("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 0);
        chk("rst_fetch_rdata", bus.fetch_rdata, 0);
        chk("rst_dbg_rdata", bus.dbg_rdata, 0);
        chk("rst_errs", {30'h0, bus.fetch_err, bus.dbg_err}, 0);
        chk("rst_mem_en_we", {30'h0, bus.mem_en, bus.mem_we}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming fetch, first grant in the release cycle
        step(1, 32'h28, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0193, 0);
        step(1, 32'h2C, 0, 0, 0, 0, 0, 1, 0, 32'h0020_0213, 0);
        step(1, 32'h30, 0, 0, 0, 0, 0, 1, 0, 32'h0030_0393, 0);
        idle();

        // Debug write contending with fetch of the same address
        step(1, 32'h40, 1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0, 1, 32'h0, 0);
        step(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0);
        idle();

        // Starvation: D,D,D,D,F then halt clears the count
        for (int i = 0; i < 7; i++) contend(0, i == 4);
        for (int i = 0; i < 3; i++) contend(1, 0);
        for (int i = 0; i < 5; i++) contend(0, i == 4);
        step(1, 32'h2C, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle();

        // Reset in the cycle after a fetch grant
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h28;
        @(negedge clk);
        chk("midrst_gnt", 32'(bus.fetch_gnt), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.fetch_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_rvalid", 32'(bus.fetch_rvalid), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_rvalid", 32'(bus.fetch_rvalid), 0);
            @(posedge clk);
            #1;
        end

        // Out-of-range fetch and misaligned debug read
        step(1, 32'h400, 0, 0, 0, 0, 0, 1, 0, EXP_OOB_F, 1);
        step(0, 0, 1, 0, 32'h42, 0, 0, 0, 1, EXP_OOB_D, 1);
        idle();
        idle();

        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Two-port arbiter and sequencer for the single-ported, synchronous-read instruction memory. It shares the memory between the core fetch port and a debug/program-loader port. The loader can write, read back, or halt fetch while it reloads the program. The block sits between the fetch stage and the instruction memory, and tracks which requester owns the one-cycle-latency read response.

## Interface
Parameters:
- `SIZE`, 256: memory depth in 32-bit words.
- `DBG_BURST`, 4: maximum number of consecutive debug grants while a fetch is pending.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  fetch read request.
- `fetch_addr`  in  32  fetch byte address.
- `fetch_gnt`  out  1  fetch request accepted this cycle.
- `fetch_rvalid`  out  1  fetch read data valid.
- `fetch_rdata`  out  32  fetch read data.
- `fetch_err`  out  1  fetch address error; qualified by `fetch_rvalid`.
- `dbg_req`  in  1  debug request.
- `dbg_we`  in  1  debug request is a write.
- `dbg_addr`  in  32  debug byte address.
- `dbg_wdata`  in  32  debug write data.
- `dbg_halt`  in  1  while high, no fetch grants are issued.
- `dbg_gnt`  out  1  debug request accepted this cycle.
- `dbg_rvalid`  out  1  debug response valid (reads and writes).
- `dbg_rdata`  out  32  debug read data.
- `dbg_err`  out  1  debug address error; qualified by `dbg_rvalid`.
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  memory byte address; the memory indexes with `addr[31:2] % SIZE`.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, valid one cycle after `mem_en`.

## Operation
- Grants are combinational from the inputs and current state. A request is accepted when `req` and `gnt` are both high in the same cycle. At most one grant is issued per cycle.
- Arbitration:
  - Debug has priority.
  - `starve_cnt` (width clog2(`DBG_BURST`)+1) increments on each debug grant while `fetch_req` is high and `dbg_halt` is low.
  - When `starve_cnt == DBG_BURST`, fetch wins the next contended cycle.
  - `starve_cnt` clears on any fetch grant, and whenever `fetch_req` is low.
- `dbg_halt` high: `fetch_gnt` = 0 and `starve_cnt` is held at 0.
- Memory drive when a request is granted: `mem_en` = 1, `mem_addr` = granted address, `mem_we` = `dbg_we` for debug grants and 0 for fetch grants, `mem_wdata` = `dbg_wdata`. With no grant: `mem_en` = 0, `mem_we` = 0.
- Response FSM, state register `rsp_state`:
  - States: `RSP_NONE`, `RSP_FETCH`, `RSP_DBG_RD`, `RSP_DBG_WR`.
  - Next state is set by the grant made this cycle. If no grant is made, the next state is `RSP_NONE`.
- Response by state:
  - `RSP_FETCH`: `fetch_rvalid` = 1, `fetch_rdata` = `mem_rdata`.
  - `RSP_DBG_RD`: `dbg_rvalid` = 1, `dbg_rdata` = `mem_rdata`.
  - `RSP_DBG_WR`: `dbg_rvalid` = 1, `dbg_rdata` = 0 (write acknowledge).
- Back-to-back grants are allowed every cycle. Response N and grant N+1 overlap in the same cycle.

## Timing
- Request accepted in cycle N → response (`rvalid`) in cycle N+1. Latency is fixed at 1 and there is no stall path.
- Outputs are combinational functions of `rsp_state` and `mem_rdata`. `rvalid` pulses for exactly one cycle per accepted request.
- Reset values: `rsp_state` = `RSP_NONE`, `starve_cnt` = 0. Resulting outputs:
  - all `gnt` and `rvalid` = 0 until the first request;
  - `rdata` = 0, `err` = 0;
  - `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Reset asserted mid-operation: a pending response is discarded and no `rvalid` is produced after `rst_n` deasserts.
- Simultaneous events:
  - Debug write and fetch read to the same address in the same cycle: only one is granted.
  - A fetch granted later to that address returns the written data.
- `dbg_halt` rising in the same cycle as a fetch request: the fetch is not granted. An already-accepted fetch still gets its response.
- Address wrap: without the bounds check, addresses at or above `SIZE`*4 alias modulo `SIZE` inside the memory.

## Configuration
- `IMEM_ARB_BOUNDS_CHECK_EN` defined:
  - A granted request with `addr[1:0]` ≠ 0 or `addr[31:2]` ≥ `SIZE` is still granted and still gets its `rvalid` in cycle N+1.
  - `mem_en` = 0 for that request, and `err` = 1 on the response.
  - `fetch_rdata` = 32'h00000013 (NOP); `dbg_rdata` = 0.
  - The error flag is registered alongside `rsp_state`.
- Not defined:
  - `fetch_err` = `dbg_err` = 0 constant.
  - All addresses are passed through unchanged; no error registers are present.

## Test plan
- Reset: hold `rst_n` low with `fetch_req` = 1 → `fetch_gnt` = 0 and `fetch_rvalid` = 0. First grant comes in the cycle `rst_n` goes high; `fetch_rvalid` follows one cycle later.
- Streaming fetch: addresses 0x28, 0x2C, 0x30 on consecutive cycles with memory returning 0x00000193, 0x00200213, 0x00300393 → `fetch_rvalid` high for 3 consecutive cycles carrying those words in order.
- Debug write then fetch: debug write 0xDEADBEEF to 0x40 contending with a fetch of 0x40 → debug granted first, `dbg_rvalid` with `dbg_rdata` = 0. The fetch is granted the next cycle and returns 0xDEADBEEF.
- Starvation: `fetch_req` and `dbg_req` held high, `DBG_BURST` = 4 → grant pattern D,D,D,D,F repeating. With `dbg_halt` = 1 the pattern is D only.
- Reset mid-read: assert `rst_n` low in the cycle after a fetch grant → no `fetch_rvalid` appears at any point after release.
- Bounds check (macro defined): fetch of 0x400 with `SIZE` = 256 → `mem_en` = 0; next cycle `fetch_rvalid` = 1, `fetch_err` = 1, `fetch_rdata` = 0x00000013. Without the macro the same request drives `mem_en` = 1 with `mem_addr` = 0x400.
